shared_timer_arbiter: RTL and testbench
=======================================

// Module: shared_timer_arbiter
// PURPOSE
//   Shares one prescaled countdown timer between NREQ requesters (pipeline
//   stages needing timed waits, e.g. settle delays, LED status holds).
//   Round-robin arbitration grants the timer to one requester. The granted
//   request counts down its programmed number of ticks and then receives a
//   one-cycle done pulse.
//   Also drives the board status LEDs: heartbeat on LEDR[9], current grant
//   on the low bits.
// PARAMETERS
//   NREQ      4         number of requesters, 1..8
//   CNT_W     32        width of each requested delay (in ticks)
//   PRESCALE  50000     clock cycles per tick (1 ms at 50 MHz), >=2
//   HB_HALF   25000000  heartbeat half-period in clock cycles, >=2
// PORTS
//   clock      in   1            system clock, all logic on posedge
//   reset      in   1            asynchronous, active-high
//   req        in   NREQ         per-requester level request; hold until done
//   req_delay  in   NREQ*CNT_W   delay in ticks, slice i = [i*CNT_W +: CNT_W]
//   grant      out  NREQ         one-hot owner of timer, 0 when idle
//   done       out  NREQ         one-cycle completion pulse to owner
//   busy       out  1            high in RUN or DONE
//   LEDR       out  10           [9]=heartbeat, [NREQ-1:0]=grant, rest 0
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, grant=0, done=0, busy=0,
//   prescaler=0, counter=0, rr_ptr=0 (req 0 highest priority), heartbeat=0.
//   Reset mid-RUN drops the grant with no done pulse.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: if any req bit is set, choose the first set bit scanning
//   rr_ptr, rr_ptr+1, ... mod NREQ. Latch its req_delay slice D into counter.
//   Assert grant[i] on the next cycle and set rr_ptr = (i+1) mod NREQ.
//   Next state is RUN if D!=0, or DONE if D==0.
// - RUN: the prescaler starts at 0 on RUN entry and counts 0..PRESCALE-1.
//   Tick = prescaler==PRESCALE-1. On each tick, counter decrements by 1.
//   A tick with counter==1 moves the FSM to DONE.
//   The first RUN cycle is cycle 0; DONE is entered exactly D*PRESCALE cycles
//   later.
// - Abort: if req[owner] is low in any RUN cycle, go to IDLE next cycle.
//   grant clears and no done pulse is produced. rr_ptr is already advanced.
// - DONE: exactly one cycle. done[owner]=1 and grant[owner] stays 1.
//   The next cycle goes to IDLE with grant=0 and done=0.
//   DONE completes even if req[owner] dropped during that cycle.
// - After done, the requester must drop req. If it is still high in IDLE, it
//   is treated as a new request and arbitrated fairly.
// - Arbitration: requests are sampled only in IDLE. Requests arriving during
//   RUN/DONE wait. req_delay is sampled once, at arbitration. Each IDLE->grant
//   decision takes 1 cycle, so back-to-back owners have a 1-cycle idle gap.
// - Width: counter is CNT_W bits unsigned. D = 2^CNT_W-1 is legal and must not
//   wrap. The counter never decrements below 0.
// - Heartbeat: free-running counter 0..HB_HALF-1, independent of FSM.
//   LEDR[9] toggles when the counter wraps.
// - done and grant are registered outputs; no combinational paths from
//   inputs to outputs.
// TESTING (sim with PRESCALE=4, HB_HALF=8, NREQ=4, CNT_W=8)
// 1 req[0]=1, D0=3 -> grant=0001 one cycle later; done[0] pulse 12 cycles
//   after the first RUN cycle; grant=0 on the following cycle.
// 2 req=1111 held and re-raised after each done, all D=1 -> grant order
//   0,1,2,3,0; each done is 4 cycles after its grant.
// 3 req[2]=1, D2=0 -> grant=0100 and done[2] on the same cycle (DONE state),
//   1 cycle after the request is sampled.
// 4 req[1] granted with D1=5, req[1] dropped after 7 RUN cycles -> grant=0 the
//   next cycle, no done; a pending req[3] is granted 1 cycle later.
// 5 reset asserted mid-RUN (async, between clock edges) -> grant, done, busy
//   and LEDR go to 0 immediately; after release, req[0] wins first.
// 6 idle 40 cycles with no req -> LEDR[9] toggles every 8 cycles,
//   LEDR[8:0]=0, busy=0.

Source files
------------

// File: rtl/shared_timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared timer arbiter.
interface shared_timer_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_delay;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  modport master (output req, req_delay, input grant, done, busy);
  modport slave  (input req, req_delay, output grant, done, busy);
endinterface

// File: rtl/shared_timer_arbiter.sv
// One prescaled countdown timer shared round-robin between NREQ requesters,
// plus a free-running heartbeat and grant display on the status LEDs.
module shared_timer_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned HB_HALF  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  shared_timer_arbiter_if.slave   bus,
  output logic [9:0]              LEDR
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned HB_W  = $clog2(HB_HALF);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] counter;
  logic [HB_W-1:0]  hb_cnt;
  logic             hb;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] pick_next;
  logic [NREQ-1:0]  pick_oh;
  logic [CNT_W-1:0] pick_delay;
  logic [PTR_W-1:0] scan;

  // First set request at or after rr_ptr; scanning backwards lets the nearest win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = PTR_W'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (bus.req[scan]) begin
        pick_valid = 1'b1;
        pick_idx   = scan;
      end
    end
    pick_next  = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    pick_oh    = NREQ'(1) << pick_idx;
    pick_delay = bus.req_delay[pick_idx*CNT_W +: CNT_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      prescaler <= '0;
      counter   <= '0;
      bus.grant <= '0;
      bus.done  <= '0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= '0;
          if (pick_valid) begin
            owner     <= pick_idx;
            rr_ptr    <= pick_next;
            counter   <= pick_delay;
            prescaler <= '0;
            bus.grant <= pick_oh;
            bus.busy  <= 1'b1;
            if (pick_delay == '0) begin
              state    <= DONE;
              bus.done <= pick_oh;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // A dropped request aborts silently; otherwise count ticks to zero.
          if (!bus.req[owner]) begin
            state     <= IDLE;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
          end else if (prescaler == PS_W'(PRESCALE - 1)) begin
            prescaler <= '0;
            if (counter != '0) begin
              counter <= counter - CNT_W'(1);
            end
            if (counter == CNT_W'(1)) begin
              state    <= DONE;
              bus.done <= bus.grant;
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.done  <= '0;
          bus.busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.done  <= '0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

  // Heartbeat toggles each time the half-period counter wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_W'(HB_HALF - 1)) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  always_comb begin
    LEDR           = '0;
    LEDR[NREQ-1:0] = bus.grant;
    LEDR[9]        = hb;
  end

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_shared_timer_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned HB_HALF  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] LEDR;
  logic [CNT_W-1:0] dly [NREQ];

  shared_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  shared_timer_arbiter #(
    .NREQ(NREQ), .CNT_W(CNT_W), .PRESCALE(PRESCALE), .HB_HALF(HB_HALF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .LEDR (LEDR)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus.req_delay = '0;
    for (int i = 0; i < NREQ; i++) bus.req_delay[i*CNT_W +: CNT_W] = dly[i];
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: the owner's wait is D*PRESCALE cycles from grant to done.
  int m_owner;
  int m_left;
  int m_ptr;
  bit m_done;

  function automatic void model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_step(logic [NREQ-1:0] r);
    int i;
    if (m_done) begin
      m_done  = 1'b0;
      m_owner = -1;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1'b1;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (r[i]) begin
          m_owner = i;
          m_ptr   = (i + 1) % NREQ;
          m_left  = int'(dly[i]) * PRESCALE;
          m_done  = (m_left == 0);
          break;
        end
      end
    end
  endfunction

  typedef struct {
    int         idx;
    int         d;
    logic [3:0] exp_grant;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [6];
  int         cnt;
  int         lat;
  logic [3:0] g;
  logic [3:0] exp_order [5];
  logic [3:0] eg;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) dly[i] = '0;
    bus.req = '0;
    reset   = 1'b1;
    @(posedge clock);
    #1;
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_done",  32'(bus.done),  32'h0);
    check("reset_busy",  32'(bus.busy),  32'h0);
    check("reset_ledr",  32'(LEDR),      32'h0);
    reset = 1'b0;

    // Single-requester transactions: grant one cycle after request, done D*4 later.
    vecs[0] = '{idx: 0, d: 3,   exp_grant: 4'b0001, exp_lat: 12};
    vecs[1] = '{idx: 2, d: 0,   exp_grant: 4'b0100, exp_lat: 0};
    vecs[2] = '{idx: 1, d: 1,   exp_grant: 4'b0010, exp_lat: 4};
    vecs[3] = '{idx: 3, d: 5,   exp_grant: 4'b1000, exp_lat: 20};
    vecs[4] = '{idx: 3, d: 255, exp_grant: 4'b1000, exp_lat: 1020};
    vecs[5] = '{idx: 1, d: 2,   exp_grant: 4'b0010, exp_lat: 8};
    for (int v = 0; v < 6; v++) begin
      dly[vecs[v].idx]     = CNT_W'(vecs[v].d);
      bus.req[vecs[v].idx] = 1'b1;
      cnt = 0;
      while (bus.grant == '0 && cnt < 10) begin cyc(); cnt++; end
      check("vec_grant_latency", 32'(cnt), 32'd1);
      check("vec_grant", 32'(bus.grant), 32'(vecs[v].exp_grant));
      check("vec_busy", 32'(bus.busy), 32'd1);
      lat = 0;
      while (bus.done == '0 && lat < 2000) begin cyc(); lat++; end
      check("vec_done_latency", 32'(lat), 32'(vecs[v].exp_lat));
      check("vec_done", 32'(bus.done), 32'(vecs[v].exp_grant));
      check("vec_grant_in_done", 32'(bus.grant), 32'(vecs[v].exp_grant));
      bus.req[vecs[v].idx] = 1'b0;
      cyc();
      check("vec_grant_after", 32'(bus.grant), 32'h0);
      check("vec_done_after",  32'(bus.done),  32'h0);
      check("vec_busy_after",  32'(bus.busy),  32'h0);
    end

    // All four requesting with D=1: round-robin order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) dly[i] = CNT_W'(1);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      while (bus.grant == '0 && cnt < 10) begin cyc(); cnt++; end
      check("rr_grant_latency", 32'(cnt), 32'd1);
      check("rr_order", 32'(bus.grant), 32'(exp_order[k]));
      g   = bus.grant;
      lat = 0;
      while (bus.done == '0 && lat < 100) begin cyc(); lat++; end
      check("rr_done_latency", 32'(lat), 32'd4);
      bus.req = bus.req & ~g;
      cyc();
      check("rr_gap", 32'(bus.grant), 32'h0);
      bus.req = bus.req | g;
    end
    bus.req = '0;
    repeat (8) cyc();

    // Abort: req[1] drops in RUN cycle 7; pending req[3] follows after one idle cycle.
    do_reset();
    dly[1]  = CNT_W'(5);
    dly[3]  = CNT_W'(2);
    bus.req = 4'b1010;
    cyc();
    check("abort_grant1", 32'(bus.grant), 32'h2);
    for (int k = 0; k < 7; k++) begin
      cyc();
      check("abort_no_done", 32'(bus.done), 32'h0);
    end
    bus.req[1] = 1'b0;
    cyc();
    check("abort_grant_clear", 32'(bus.grant), 32'h0);
    check("abort_done_clear",  32'(bus.done),  32'h0);
    check("abort_busy_clear",  32'(bus.busy),  32'h0);
    cyc();
    check("abort_next_grant", 32'(bus.grant), 32'h8);
    lat = 0;
    while (bus.done == '0 && lat < 100) begin cyc(); lat++; end
    check("abort_next_done_latency", 32'(lat), 32'd8);
    bus.req = '0;
    cyc();

    // Asynchronous reset in the middle of RUN.
    do_reset();
    dly[0]  = CNT_W'(3);
    dly[2]  = CNT_W'(1);
    bus.req = 4'b0001;
    cyc();
    check("areset_pre_grant", 32'(bus.grant), 32'h1);
    repeat (3) cyc();
    bus.req = 4'b0101;
    #2;
    reset = 1'b1;
    #1;
    check("areset_grant", 32'(bus.grant), 32'h0);
    check("areset_done",  32'(bus.done),  32'h0);
    check("areset_busy",  32'(bus.busy),  32'h0);
    check("areset_ledr",  32'(LEDR),      32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc();
    check("areset_first_winner", 32'(bus.grant), 32'h1);
    bus.req = '0;
    repeat (3) cyc();

    // Idle heartbeat: LEDR[9] flips every 8 cycles from reset, everything else quiet.
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      cyc();
      check("hb_ledr9", 32'(LEDR[9]), 32'((n / 8) % 2));
      check("hb_ledr_low", 32'(LEDR[8:0]), 32'h0);
      check("hb_busy", 32'(bus.busy), 32'h0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock);
      model_step(bus.req);
      #1;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      check("rand_grant", 32'(bus.grant), 32'(eg));
      check("rand_done",  32'(bus.done),  32'(m_done ? eg : 4'b0));
      check("rand_busy",  32'(bus.busy),  32'(m_owner >= 0));
      check("rand_ledr_grant", 32'(LEDR[3:0]), 32'(eg));
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && m_done && m_owner == i) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(0, 49) == 0) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 5) == 0) bus.req[i] = 1'b1;
        if ($urandom_range(0, 9) == 0) dly[i] = CNT_W'($urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
